// File: rtl/delay_temp_unit.sv
// delay_temp_unit
// Datapath-side responder for the stepper-processor control FSM.
// - Delay timer: a prescaled tick counter that reports delay_done once the
//   programmed number of ticks has elapsed. It only advances while enabled.
// - Temp register: a signed step count that can be loaded, incremented or
//   decremented. Its sign and zero flags are decoded from the register.

module delay_temp_unit #(
  parameter int DATA_W     = 8,
  parameter int DELAY_W    = 8,
  parameter int PRESCALE   = 50000,
  parameter int PRESCALE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_delay_counter,
  input  logic               enable_delay_counter,
  input  logic [DELAY_W-1:0] delay_value,
  output logic               delay_done,
  output logic               delay_busy,
  input  logic               load_temp_register,
  input  logic               increment_temp_register,
  input  logic               decrement_temp_register,
  input  logic [DATA_W-1:0]  temp_load_value,
  output logic [DATA_W-1:0]  temp_value,
  output logic               temp_is_positive,
  output logic               temp_is_negative,
  output logic               temp_is_zero
);

  // Last prescaler value before a tick is consumed.
  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [DELAY_W-1:0]    DELAY_ZERO    = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0]    DELAY_ONE     = DELAY_W'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ZERO      = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PRE_ONE       = PRESCALE_W'(1);
  localparam logic [DATA_W-1:0]     DATA_ZERO     = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]     DATA_ONE      = DATA_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DELAY_W-1:0]    remaining;
  logic [DELAY_W-1:0]    remaining_next;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] prescale_next;
  logic [DATA_W-1:0]     temp_next;

  // Delay FSM next state: start restarts from any state and beats enable.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    prescale_next  = prescale;
    if (start_delay_counter) begin
      remaining_next = delay_value;
      prescale_next  = PRE_ZERO;
      if (delay_value == DELAY_ZERO) begin
        state_next = DONE;
      end else begin
        state_next = COUNT;
      end
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        COUNT: begin
          if (enable_delay_counter) begin
            if (prescale == PRESCALE_LAST) begin
              prescale_next  = PRE_ZERO;
              remaining_next = remaining - DELAY_ONE;
              if (remaining == DELAY_ONE) begin
                state_next = DONE;
              end else begin
                state_next = COUNT;
              end
            end else begin
              prescale_next = prescale + PRE_ONE;
            end
          end else begin
            // Paused: keep all progress.
            state_next = COUNT;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next     = IDLE;
          remaining_next = DELAY_ZERO;
          prescale_next  = PRE_ZERO;
        end
      endcase
    end
  end

  // Delay FSM registers; status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      remaining  <= DELAY_ZERO;
      prescale   <= PRE_ZERO;
      delay_done <= 1'b0;
      delay_busy <= 1'b0;
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      prescale   <= prescale_next;
      delay_done <= (state_next == DONE);
      delay_busy <= (state_next == COUNT);
    end
  end

  // Temp register next value: load wins, opposing inc/dec cancel out.
  always_comb begin
    temp_next = temp_value;
    if (load_temp_register) begin
      temp_next = temp_load_value;
    end else if (increment_temp_register && !decrement_temp_register) begin
      temp_next = temp_value + DATA_ONE;
    end else if (decrement_temp_register && !increment_temp_register) begin
      temp_next = temp_value - DATA_ONE;
    end else begin
      temp_next = temp_value;
    end
  end

  // Temp register storage (two's complement, wraps naturally).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      temp_value <= DATA_ZERO;
    end else begin
      temp_value <= temp_next;
    end
  end

  // Flags decoded from the registered value; exactly one is ever set.
  assign temp_is_zero     = (temp_value == DATA_ZERO);
  assign temp_is_negative = temp_value[DATA_W-1];
  assign temp_is_positive = !temp_value[DATA_W-1] && (temp_value != DATA_ZERO);

endmodule
